pixel_fetch_ctrl: RTL and testbench

PIXEL_FETCH_CTRL -- requirements
Module: pixel_fetch_ctrl

---
 rtl/vga_pkg.sv | 24 ++
 rtl/pixel_fetch_ctrl_if.sv | 42 ++++
 rtl/pixel_skid_buf.sv | 56 +++++
 rtl/pixel_fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_pixel_fetch_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: types and defaults shared by the pixel fetch controller.
//   H_ACTIVE_DEF / V_ACTIVE_DEF : default active raster (640x480)
//   color_t                     : 24-bit {r,g,b} pixel
//   fetch_state_t               : fetch FSM states (IDLE, FETCH, DRAIN)
//   last_pixel()                : index of the final pixel in a frame
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned COLOR_W      = 24;

  typedef logic [COLOR_W-1:0] color_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  function automatic int unsigned last_pixel(input int unsigned h, input int unsigned v);
    return (h * v) - 1;
  endfunction

endpackage

// File: rtl/pixel_fetch_ctrl_if.sv
// pixel_fetch_ctrl_if: frame/ROM/FIFO signal bundle of the pixel fetch controller.
//   master modport : controller side (drives rom_rd/rom_addr, fifo_wr_en/fifo_din,
//                    busy, frame_done and, with PIXEL_FETCH_UNDERFLOW_CNT_EN,
//                    underflow_cnt)
//   slave modport  : environment side (timing generator, ROM, FIFO, display)
interface pixel_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 19
);
  import vga_pkg::*;

  logic              frame_start;
  logic              rom_rd;
  logic [ADDR_W-1:0] rom_addr;
  color_t            rom_color;
  logic              fifo_full;
  logic              fifo_wr_en;
  color_t            fifo_din;
  logic              fifo_empty;
  logic              display_active;
  logic              busy;
  logic              frame_done;
`ifdef PIXEL_FETCH_UNDERFLOW_CNT_EN
  logic [15:0]       underflow_cnt;
`endif

  modport master (
`ifdef PIXEL_FETCH_UNDERFLOW_CNT_EN
    output underflow_cnt,
`endif
    input  frame_start, rom_color, fifo_full, fifo_empty, display_active,
    output rom_rd, rom_addr, fifo_wr_en, fifo_din, busy, frame_done
  );

  modport slave (
`ifdef PIXEL_FETCH_UNDERFLOW_CNT_EN
    input  underflow_cnt,
`endif
    output frame_start, rom_color, fifo_full, fifo_empty, display_active,
    input  rom_rd, rom_addr, fifo_wr_en, fifo_din, busy, frame_done
  );

endinterface

// File: rtl/pixel_skid_buf.sv
// pixel_skid_buf: one-entry hold register between ROM return data and the FIFO.
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_flush         : drop returning and held data (frame abort)
//   i_ret_valid     : ROM data is returning this cycle
//   i_ret_data      : returning ROM word
//   i_fifo_full     : FIFO cannot accept a write this cycle
//   o_wr_en         : FIFO write strobe
//   o_wr_data       : FIFO write data (zero when not writing)
//   o_hold_valid    : a word is parked in the hold register
module pixel_skid_buf
  import vga_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_flush,
  input  logic   i_ret_valid,
  input  color_t i_ret_data,
  input  logic   i_fifo_full,
  output logic   o_wr_en,
  output color_t o_wr_data,
  output logic   o_hold_valid
);

  logic   r_hold_valid;
  color_t r_hold_data;
  logic   w_wr_en;

  // A held word and a returning word never coexist: reads only issue while
  // the hold register is empty, so the held word always goes out first.
  always_comb begin
    w_wr_en   = !i_flush && !i_fifo_full && (r_hold_valid || i_ret_valid);
    o_wr_data = '0;
    if (w_wr_en) begin
      o_wr_data = r_hold_valid ? r_hold_data : i_ret_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (i_flush) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (i_ret_valid && i_fifo_full) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= i_ret_data;
    end else if (r_hold_valid && !i_fifo_full) begin
      r_hold_valid <= 1'b0;
    end
  end

  assign o_wr_en      = w_wr_en;
  assign o_hold_valid = r_hold_valid;

endmodule

// File: rtl/pixel_fetch_ctrl.sv
// pixel_fetch_ctrl: reads one frame of pixels from ROM in row-major order and
// streams them into the display FIFO with back-pressure.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : pixel_fetch_ctrl_if.master -- frame_start in; rom_rd/rom_addr out,
//              rom_color in (1 cycle after rom_rd); fifo_full in, fifo_wr_en/
//              fifo_din out; fifo_empty/display_active in; busy/frame_done out
// Optional: define PIXEL_FETCH_UNDERFLOW_CNT_EN to add the saturating 16-bit
// underflow_cnt output (counts display_active & fifo_empty cycles, cleared on
// frame_start).
module pixel_fetch_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned ADDR_W   = 19
)(
  input  logic               clk,
  input  logic               rst,
  pixel_fetch_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(last_pixel(H_ACTIVE, V_ACTIVE));

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_inflight;
  logic              w_rom_rd;
  logic              w_frame_done;
  logic              w_abort;
  logic              w_hold_valid;
  logic              w_wr_en;
  color_t            w_wr_data;

  // frame_start while busy restarts the frame; the word returning in that
  // cycle and any held word are flushed instead of written.
  assign w_abort = bus.frame_start && (r_state != IDLE);

  pixel_skid_buf u_skid (
    .i_clk        (clk),
    .i_rst_n      (rst),
    .i_flush      (w_abort),
    .i_ret_valid  (r_inflight),
    .i_ret_data   (bus.rom_color),
    .i_fifo_full  (bus.fifo_full),
    .o_wr_en      (w_wr_en),
    .o_wr_data    (w_wr_data),
    .o_hold_valid (w_hold_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rom_rd     = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.frame_start) begin
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (bus.frame_start) begin
          w_state_nxt = FETCH;
        end else begin
          w_rom_rd = !bus.fifo_full && !w_hold_valid;
          if (w_rom_rd && (r_addr == LAST_ADDR)) begin
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (bus.frame_start) begin
          w_state_nxt = FETCH;
        end else if (!r_inflight && !w_hold_valid) begin
          w_frame_done = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rom_rd;
      if (bus.frame_start) begin
        r_addr <= '0;
      end else if (w_rom_rd) begin
        r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_W'(1);
      end
    end
  end

  assign bus.rom_rd     = w_rom_rd;
  assign bus.rom_addr   = r_addr;
  assign bus.fifo_wr_en = w_wr_en;
  assign bus.fifo_din   = w_wr_data;
  assign bus.busy       = (r_state != IDLE);
  assign bus.frame_done = w_frame_done;

`ifdef PIXEL_FETCH_UNDERFLOW_CNT_EN
  logic [15:0] r_uf_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_uf_cnt <= '0;
    end else if (bus.frame_start) begin
      r_uf_cnt <= '0;
    end else if (bus.display_active && bus.fifo_empty && (r_uf_cnt != '1)) begin
      r_uf_cnt <= r_uf_cnt + 16'd1;
    end
  end

  assign bus.underflow_cnt = r_uf_cnt;
`else
  logic w_unused_uf;
  assign w_unused_uf = bus.fifo_empty ^ bus.display_active;
`endif

endmodule

// File: tb/tb_pixel_fetch_ctrl.sv
module tb_pixel_fetch_ctrl;
  import vga_pkg::*;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 2;
  localparam int unsigned N  = H * V;
  localparam int unsigned AW = 19;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pixel_fetch_ctrl_if #(.ADDR_W(AW)) bus ();

  pixel_fetch_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: expected FIFO word stream, next expected ROM address,
  // whether a frame is open, and whether a returned word is parked.
  color_t      exp_q[$];
  int unsigned exp_addr   = 0;
  bit          frame_open = 1'b0;
  bit          m_prev_rd  = 1'b0;
  bit          m_held     = 1'b0;
  int unsigned done_cnt   = 0;
  int unsigned cyc        = 0;

  function automatic color_t color_of(input int unsigned a);
    logic [31:0] h;
    h = a * 32'd79873 + 32'h00A55A3C;
    return h[23:0];
  endfunction

  // ROM: data valid exactly one cycle after a read, junk otherwise.
  logic          rom_v = 1'b0;
  logic [AW-1:0] rom_a = '0;
  always @(posedge clk) begin
    rom_v <= bus.rom_rd;
    rom_a <= bus.rom_addr;
  end
  assign bus.rom_color = rom_v ? color_of(32'(rom_a)) : 24'h5C5C5C;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    bit exp_rd;
    bit exp_wr;
    bit exp_done;
    cyc++;
    if (!rst) begin
      m_prev_rd = 1'b0;
      m_held    = 1'b0;
    end else if (bus.frame_start) begin
      check("start_no_wr",   32'(bus.fifo_wr_en), 32'd0);
      check("start_no_rd",   32'(bus.rom_rd),     32'd0);
      check("start_no_done", 32'(bus.frame_done), 32'd0);
      m_prev_rd = 1'b0;
      m_held    = 1'b0;
    end else begin
      exp_rd   = frame_open && (exp_addr < N) && !m_held && !bus.fifo_full;
      exp_wr   = (m_held || m_prev_rd) && !bus.fifo_full;
      exp_done = frame_open && (exp_addr == N) && !m_held && !m_prev_rd;

      check("busy",   32'(bus.busy),   32'(frame_open));
      check("rom_rd", 32'(bus.rom_rd), 32'(exp_rd));
      if (exp_rd) check("rom_addr", 32'(bus.rom_addr), exp_addr);
      check("wr_en",  32'(bus.fifo_wr_en), 32'(exp_wr));
      if (bus.fifo_wr_en) begin
        if (exp_q.size() == 0) check("wr_unexpected", 32'(bus.fifo_wr_en), 32'd0);
        else                   check("wr_data", 32'(bus.fifo_din), 32'(exp_q.pop_front()));
      end
      check("frame_done", 32'(bus.frame_done), 32'(exp_done));
      if (exp_done) check("done_all_written", 32'(exp_q.size()), 32'd0);
      if (bus.frame_done) done_cnt++;

      if (m_held) begin
        if (exp_wr) m_held = 1'b0;
      end else if (m_prev_rd && !exp_wr) begin
        m_held = 1'b1;
      end
      m_prev_rd = exp_rd;
      if (exp_rd) exp_addr++;
      if (exp_done) frame_open = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    exp_q.delete();
    for (int unsigned i = 0; i < N; i++) exp_q.push_back(color_of(i));
    exp_addr   = 0;
    frame_open = 1'b1;
  endtask

  task automatic run_until_done(input int unsigned budget, input bit rnd);
    int unsigned start_cnt;
    start_cnt = done_cnt;
    for (int unsigned k = 0; k < budget; k++) begin
      step();
      bus.frame_start = 1'b0;
      if (done_cnt != start_cnt) break;
      if (rnd) begin
        bus.fifo_full = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 49) == 0) start_frame();
      end
    end
    bus.frame_start = 1'b0;
    bus.fifo_full   = 1'b0;
    check("frame_done_seen", 32'(done_cnt != start_cnt), 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rom_rd"},     32'(bus.rom_rd),     32'd0);
    check({tag, "_rom_addr"},   32'(bus.rom_addr),   32'd0);
    check({tag, "_fifo_wr_en"}, 32'(bus.fifo_wr_en), 32'd0);
    check({tag, "_fifo_din"},   32'(bus.fifo_din),   32'd0);
    check({tag, "_busy"},       32'(bus.busy),       32'd0);
    check({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
  endtask

  initial begin
    bus.frame_start    = 1'b0;
    bus.fifo_full      = 1'b0;
    bus.fifo_empty     = 1'b0;
    bus.display_active = 1'b0;
    rst                = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b1;
    step();
    step();

    // Clean frame: 8 back-to-back reads, first write two cycles after start.
    start_frame();
    step();
    bus.frame_start = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      @(negedge clk);
      check("seq_rd",   32'(bus.rom_rd),   32'd1);
      check("seq_addr", 32'(bus.rom_addr), i);
      if (i >= 1) begin
        check("seq_wr",  32'(bus.fifo_wr_en), 32'd1);
        check("seq_din", 32'(bus.fifo_din),   32'(color_of(i - 1)));
      end
    end
    run_until_done(20, 1'b0);

    // Back-pressure on the return cycle of address 2.
    step();
    start_frame();
    step();
    bus.frame_start = 1'b0;
    step();
    step();
    step();
    bus.fifo_full = 1'b1;
    step();
    step();
    step();
    bus.fifo_full = 1'b0;
    @(negedge clk);
    check("held_wr",   32'(bus.fifo_wr_en), 32'd1);
    check("held_din",  32'(bus.fifo_din),   32'(color_of(2)));
    check("held_no_rd", 32'(bus.rom_rd),    32'd0);
    run_until_done(40, 1'b0);

    // Abort after address 5 has been issued.
    step();
    start_frame();
    step();
    bus.frame_start = 1'b0;
    repeat (6) step();
    start_frame();
    step();
    bus.frame_start = 1'b0;
    @(negedge clk);
    check("abort_rd",   32'(bus.rom_rd),   32'd1);
    check("abort_addr", 32'(bus.rom_addr), 32'd0);
    run_until_done(40, 1'b0);

    // Reset pulse in the middle of a frame.
    step();
    start_frame();
    step();
    bus.frame_start = 1'b0;
    step();
    step();
    #1;
    rst = 1'b0;
    exp_q.delete();
    frame_open = 1'b0;
    exp_addr   = 0;
    #1;
    check_outputs_zero("midrst");
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (15) step();

    // Randomised back-pressure with occasional restarts.
    repeat (25) begin
      step();
      start_frame();
      run_until_done(400, 1'b1);
    end

`ifdef PIXEL_FETCH_UNDERFLOW_CNT_EN
    step();
    bus.display_active = 1'b1;
    bus.fifo_empty     = 1'b1;
    repeat (5) step();
    bus.display_active = 1'b0;
    bus.fifo_empty     = 1'b0;
    check("uf_cnt_5", 32'(bus.underflow_cnt), 32'd5);
    step();
    start_frame();
    step();
    bus.frame_start = 1'b0;
    check("uf_cnt_clr", 32'(bus.underflow_cnt), 32'd0);
    run_until_done(40, 1'b0);
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
